bram_bist_ctrl: RTL and testbench
=================================

Name: bram_bist_ctrl

Overview:
Parametrised successor to the single-port BRAM write/read sequencer. It writes a selectable data pattern over a configurable address window, then reads the window back. Each read word is compared against the expected pattern, with compensation for a configurable memory read latency. It reports the error count, the first failing address and pass/fail, and sits between a test/CPU front end and an external spbram-style single-port memory.

Parameters:
DWIDTH, 8, memory data width (bits)
AWIDTH, 8, memory address width (bits)
RD_LAT, 1, cycles from address/ce0 to valid q0 (1..4)
CW, AWIDTH+1, count width so that a full 2^AWIDTH sweep is expressible

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
i_run  in  1  start pulse; accepted only in IDLE
i_abort  in  1  terminate current run
i_num_cnt  in  CW  number of words to test, 0..2^AWIDTH
i_start_addr  in  AWIDTH  first address of window
i_mode  in  2  pattern: 0 addr, 1 ~addr, 2 seed^addr, 3 constant seed
i_seed  in  DWIDTH  pattern seed
addr0  out  AWIDTH  memory address
d0  out  DWIDTH  memory write data
ce0  out  1  memory chip enable
we0  out  1  memory write enable
q0  in  DWIDTH  memory read data
o_idle, o_write, o_read, o_drain, o_done  out  1 each  one-hot state flags
o_err_cnt  out  CW  mismatch count of last run
o_first_err_addr  out  AWIDTH  address of first mismatch (0 if none)
o_pass  out  1  1 when last run finished, was not aborted and had o_err_cnt==0
o_aborted  out  1  last run was aborted

Behaviour:
- Reset: state IDLE; addr0, d0, ce0, we0 = 0; o_err_cnt, o_first_err_addr, o_pass, o_aborted = 0; all internal counters and pipelines = 0.
- i_run in IDLE latches i_num_cnt, i_start_addr, i_mode and i_seed; clears all result outputs. i_run outside IDLE is ignored.
- i_num_cnt==0 at accept: go directly to DONE next cycle, with o_pass=1 and o_err_cnt=0.
- WRITE: lasts N cycles.
  - Each cycle: ce0=1, we0=1, addr0=start+k (mod 2^AWIDTH; the window wraps), d0=pattern(mode, addr0).
  - After cycle k==N-1, go to READ.
- READ: lasts N cycles with ce0=1 and we0=0 over the same address sequence.
  - The expected word and its address travel down an RD_LAT-deep valid pipeline.
  - Then go to DRAIN.
- DRAIN: lasts RD_LAT cycles with ce0=0, to flush outstanding reads; then go to DONE.
- Compare: on each cycle where the pipeline output is valid, compare q0 against the expected word.
  - On mismatch, o_err_cnt increments.
  - On the first mismatch only, o_first_err_addr is captured.
- DONE: lasts one cycle; o_pass is set on entry. Then return to IDLE. Results hold until the next accepted i_run.
- addr0, d0, ce0 and we0 are combinational from state and counter, as in the predecessor. Outputs are 0 in IDLE, DRAIN and DONE.
- i_abort in WRITE, READ or DRAIN goes to DONE next cycle.
  - ce0 and we0 drop immediately (combinationally).
  - o_aborted=1 and o_pass=0.
  - Compares still in flight are discarded.
  - i_abort in IDLE or DONE has no effect.
- Simultaneous i_run and i_abort in IDLE: i_run wins.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values. Memory contents are unspecified.
- o_err_cnt cannot overflow, since it is at most N ≤ 2^AWIDTH and it is CW bits wide.

Decomposition:
- Package bram_bist_pkg holds:
  - state encodings IDLE=0, WRITE=1, READ=2, DRAIN=3, DONE=4 (3-bit);
  - mode constants MODE_ADDR, MODE_INV, MODE_XOR, MODE_CONST;
  - the pattern function.
- Sub-module bram_bist_pattern: combinational pattern generator taking (mode, seed, addr) and producing data. It is used once for d0 and once for the expected word.
- Memory stays external. The bench instantiates spbram, with a latency wrapper for RD_LAT>1.

Test Plan:
- Mode 0, start=0, N=16, RD_LAT=1, clean memory -> 16 WRITE and 16 READ cycles, 1 DRAIN, 1 DONE; o_pass=1, o_err_cnt=0; total 34 cycles from accept to IDLE.
- Mode 2, seed=0xA5, start=0xF8, N=16 -> addresses wrap 0xF8..0xFF, 0x00..0x07; d0 at 0x00 is 0xA5; pass.
- Bench forces q0 bit flip at addr 0x03 and 0x09 (N=16, start=0) -> o_err_cnt=2, o_first_err_addr=0x03, o_pass=0.
- RD_LAT=3, N=8, mode 1 -> DRAIN lasts 3 cycles, no false mismatches, pass; repeat with i_run asserted during READ -> ignored.
- i_abort at 5th READ cycle -> DONE next cycle, o_aborted=1, o_pass=0; next i_run clears results and completes a clean run.
- N=0 -> DONE one cycle after accept, o_pass=1; N=256 (AWIDTH=8) -> full sweep, o_err_cnt width holds 256 on an all-fail memory.

Source files
------------

// File: rtl/bram_bist_pkg.sv
// rtl/bram_bist_pkg.sv - shared state encodings, pattern modes and pattern function for the BRAM BIST
package bram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_ADDR  = 2'd0;
    localparam logic [1:0] MODE_INV   = 2'd1;
    localparam logic [1:0] MODE_XOR   = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    // Computed at 32 bits; callers zero-extend inputs and keep the low DWIDTH bits.
    function automatic logic [31:0] pattern(input logic [1:0]  mode,
                                            input logic [31:0] seed,
                                            input logic [31:0] addr);
        case (mode)
            MODE_ADDR: return addr;
            MODE_INV:  return ~addr;
            MODE_XOR:  return seed ^ addr;
            default:   return seed;
        endcase
    endfunction

endpackage

// File: rtl/bram_bist_ctrl_if.sv
// rtl/bram_bist_ctrl_if.sv - single-port memory bus between the BIST controller and the BRAM
interface bram_bist_ctrl_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
);
    logic [AWIDTH-1:0] addr0;
    logic [DWIDTH-1:0] d0;
    logic              ce0;
    logic              we0;
    logic [DWIDTH-1:0] q0;

    modport master (output addr0, output d0, output ce0, output we0, input q0);
    modport slave  (input addr0, input d0, input ce0, input we0, output q0);
endinterface

// File: rtl/bram_bist_pattern.sv
// rtl/bram_bist_pattern.sv - combinational test pattern generator for one address
module bram_bist_pattern
    import bram_bist_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic [1:0]        mode,
    input  logic [DWIDTH-1:0] seed,
    input  logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] data
);

    logic [31:0] pat_full;
    logic        unused_pat;

    assign pat_full   = pattern(mode, 32'(seed), 32'(addr));
    assign data       = pat_full[DWIDTH-1:0];
    assign unused_pat = ^pat_full;

endmodule

// File: rtl/bram_bist_ctrl.sv
// rtl/bram_bist_ctrl.sv - write/readback BIST sequencer for an external single-port BRAM
module bram_bist_ctrl
    import bram_bist_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int RD_LAT = 1,
    parameter int CW     = AWIDTH + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    input  logic              i_abort,
    input  logic [CW-1:0]     i_num_cnt,
    input  logic [AWIDTH-1:0] i_start_addr,
    input  logic [1:0]        i_mode,
    input  logic [DWIDTH-1:0] i_seed,
    bram_bist_ctrl_if.master  mem,
    output logic              o_idle,
    output logic              o_write,
    output logic              o_read,
    output logic              o_drain,
    output logic              o_done,
    output logic [CW-1:0]     o_err_cnt,
    output logic [AWIDTH-1:0] o_first_err_addr,
    output logic              o_pass,
    output logic              o_aborted
);

    state_t            state;
    logic [CW-1:0]     num_cnt;
    logic [AWIDTH-1:0] start_addr;
    logic [1:0]        mode;
    logic [DWIDTH-1:0] seed;
    logic [CW-1:0]     k;

    logic              pipe_vld  [RD_LAT];
    logic [AWIDTH-1:0] pipe_addr [RD_LAT];
    logic [DWIDTH-1:0] pipe_exp  [RD_LAT];

    logic [AWIDTH-1:0] cur_addr;
    logic [DWIDTH-1:0] pat_wr;
    logic [DWIDTH-1:0] pat_exp;
    logic              active;
    logic              abort_now;
    logic              last_word;
    logic              cmp_vld;
    logic              mismatch;
    logic [CW-1:0]     err_next;

    assign cur_addr  = start_addr + k[AWIDTH-1:0];
    assign active    = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign abort_now = i_abort && active;
    assign last_word = (k == num_cnt - CW'(1));

    // Compares landing in the abort cycle belong to the discarded run.
    assign cmp_vld  = pipe_vld[RD_LAT-1] && !abort_now;
    assign mismatch = cmp_vld && (mem.q0 != pipe_exp[RD_LAT-1]);
    assign err_next = o_err_cnt + CW'(mismatch);

    bram_bist_pattern #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_pat_wr (
        .mode (mode),
        .seed (seed),
        .addr (cur_addr),
        .data (pat_wr)
    );

    bram_bist_pattern #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_pat_exp (
        .mode (mode),
        .seed (seed),
        .addr (cur_addr),
        .data (pat_exp)
    );

    always_comb begin
        mem.addr0 = '0;
        mem.d0    = '0;
        mem.ce0   = 1'b0;
        mem.we0   = 1'b0;
        if (state == WRITE) begin
            mem.addr0 = cur_addr;
            mem.d0    = pat_wr;
            mem.ce0   = !i_abort;
            mem.we0   = !i_abort;
        end else if (state == READ) begin
            mem.addr0 = cur_addr;
            mem.ce0   = !i_abort;
        end
    end

    // Expected word and address ride alongside the memory's read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
                pipe_exp[i]  <= '0;
            end
        end else if (abort_now) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
            end
        end else begin
            pipe_vld[0]  <= (state == READ);
            pipe_addr[0] <= cur_addr;
            pipe_exp[0]  <= pat_exp;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            num_cnt          <= '0;
            start_addr       <= '0;
            mode             <= MODE_ADDR;
            seed             <= '0;
            k                <= '0;
            o_err_cnt        <= '0;
            o_first_err_addr <= '0;
            o_pass           <= 1'b0;
            o_aborted        <= 1'b0;
        end else begin
            if (mismatch) begin
                o_err_cnt <= err_next;
                if (o_err_cnt == '0) begin
                    o_first_err_addr <= pipe_addr[RD_LAT-1];
                end
            end
            if (abort_now) begin
                state     <= DONE;
                k         <= '0;
                o_pass    <= 1'b0;
                o_aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_run) begin
                            num_cnt          <= i_num_cnt;
                            start_addr       <= i_start_addr;
                            mode             <= i_mode;
                            seed             <= i_seed;
                            k                <= '0;
                            o_err_cnt        <= '0;
                            o_first_err_addr <= '0;
                            o_aborted        <= 1'b0;
                            o_pass           <= (i_num_cnt == '0);
                            state            <= (i_num_cnt == '0) ? DONE : WRITE;
                        end
                    end
                    WRITE: begin
                        if (last_word) begin
                            state <= READ;
                            k     <= '0;
                        end else begin
                            k <= k + CW'(1);
                        end
                    end
                    READ: begin
                        if (last_word) begin
                            state <= DRAIN;
                            k     <= '0;
                        end else begin
                            k <= k + CW'(1);
                        end
                    end
                    DRAIN: begin
                        if (k == CW'(RD_LAT - 1)) begin
                            state  <= DONE;
                            k      <= '0;
                            o_pass <= (err_next == '0);
                        end else begin
                            k <= k + CW'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_idle  = (state == IDLE);
    assign o_write = (state == WRITE);
    assign o_read  = (state == READ);
    assign o_drain = (state == DRAIN);
    assign o_done  = (state == DONE);

endmodule

// File: tb/tb_bram_bist_ctrl.sv
// tb/tb_bram_bist_ctrl.sv - scoreboard bench for bram_bist_ctrl at read latencies 1 and 3
module tb_bram_bist_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int CW = AW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          run;
    logic          abort;
    logic          sel;
    logic [CW-1:0] num;
    logic [AW-1:0] start;
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    logic [255:0]  bad;

    logic run_a, run_b, abort_a, abort_b;
    assign run_a   = run & ~sel;
    assign run_b   = run & sel;
    assign abort_a = abort & ~sel;
    assign abort_b = abort & sel;

    bram_bist_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) m1 ();
    bram_bist_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) m3 ();

    logic          idle_a, wr_a, rd_a, dr_a, dn_a, pass_a, ab_a;
    logic          idle_b, wr_b, rd_b, dr_b, dn_b, pass_b, ab_b;
    logic [CW-1:0] err_a, err_b;
    logic [AW-1:0] fea_a, fea_b;

    bram_bist_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(1), .CW(CW)) dut1 (
        .clk(clk), .reset_n(reset_n), .i_run(run_a), .i_abort(abort_a),
        .i_num_cnt(num), .i_start_addr(start), .i_mode(mode), .i_seed(seed),
        .mem(m1),
        .o_idle(idle_a), .o_write(wr_a), .o_read(rd_a), .o_drain(dr_a), .o_done(dn_a),
        .o_err_cnt(err_a), .o_first_err_addr(fea_a), .o_pass(pass_a), .o_aborted(ab_a)
    );

    bram_bist_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(3), .CW(CW)) dut3 (
        .clk(clk), .reset_n(reset_n), .i_run(run_b), .i_abort(abort_b),
        .i_num_cnt(num), .i_start_addr(start), .i_mode(mode), .i_seed(seed),
        .mem(m3),
        .o_idle(idle_b), .o_write(wr_b), .o_read(rd_b), .o_drain(dr_b), .o_done(dn_b),
        .o_err_cnt(err_b), .o_first_err_addr(fea_b), .o_pass(pass_b), .o_aborted(ab_b)
    );

    // Single-port memories; bad[] flips bit 0 of data read from that address.
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] rq_a, rq_b, dl1_b, dl2_b;

    always @(posedge clk) begin
        if (m1.ce0) begin
            if (m1.we0) mem_a[m1.addr0] <= m1.d0;
            else        rq_a <= mem_a[m1.addr0] ^ DW'(bad[m1.addr0]);
        end
        if (m3.ce0) begin
            if (m3.we0) mem_b[m3.addr0] <= m3.d0;
            else        rq_b <= mem_b[m3.addr0] ^ DW'(bad[m3.addr0]);
        end
        dl1_b <= rq_b;
        dl2_b <= dl1_b;
    end
    assign m1.q0 = rq_a;
    assign m3.q0 = dl2_b;

    logic          s_idle, s_wr, s_rd, s_dr, s_dn, s_pass, s_ab, s_ce, s_we;
    logic [CW-1:0] s_err;
    logic [AW-1:0] s_fea, s_addr;
    logic [DW-1:0] s_d0;

    always_comb begin
        s_idle = sel ? idle_b : idle_a;
        s_wr   = sel ? wr_b   : wr_a;
        s_rd   = sel ? rd_b   : rd_a;
        s_dr   = sel ? dr_b   : dr_a;
        s_dn   = sel ? dn_b   : dn_a;
        s_pass = sel ? pass_b : pass_a;
        s_ab   = sel ? ab_b   : ab_a;
        s_err  = sel ? err_b  : err_a;
        s_fea  = sel ? fea_b  : fea_a;
        s_addr = sel ? m3.addr0 : m1.addr0;
        s_d0   = sel ? m3.d0    : m1.d0;
        s_ce   = sel ? m3.ce0   : m1.ce0;
        s_we   = sel ? m3.we0   : m1.we0;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [1:0] md, input logic [7:0] sd, input logic [7:0] a);
        case (md)
            2'd0:    pat = a;
            2'd1:    pat = ~a;
            2'd2:    pat = sd ^ a;
            default: pat = sd;
        endcase
    endfunction

    typedef struct {
        logic [31:0] err;
        logic [31:0] first;
        logic        pass;
        logic        aborted;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset_n && s_dn) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("err_cnt", s_err, mon_e.err);
                check_eq("first_err", s_fea, mon_e.first);
                check_eq("pass", s_pass, mon_e.pass);
                check_eq("aborted", s_ab, mon_e.aborted);
            end
        end
    end

    task automatic run_test(input logic which, input int n, input logic [7:0] st,
                            input logic [1:0] md, input logic [7:0] sd,
                            input int abort_at, input bit run_in_read);
        exp_t e;
        int nw, nr, nd, ndn, tot, lat;
        logic [7:0] a;
        lat = which ? 3 : 1;
        e.err = 0; e.first = 0;
        if (abort_at < 0) begin
            for (int i = 0; i < n; i++) begin
                a = 8'(st + i);
                if (bad[a]) begin
                    if (e.err == 0) e.first = 32'(a);
                    e.err++;
                end
            end
        end
        e.pass    = (abort_at < 0) && (e.err == 0);
        e.aborted = (abort_at >= 0);
        sel = which; num = CW'(n); start = st; mode = md; seed = sd;
        run = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        run = 1'b0;
        nw = 0; nr = 0; nd = 0; ndn = 0; tot = 0;
        while (!s_idle && tot < 700) begin
            if (s_wr) begin
                check_eq("wr_addr", s_addr, 8'(st + nw));
                check_eq("wr_data", s_d0, pat(md, sd, 8'(st + nw)));
                check_eq("wr_ctl", {s_ce, s_we}, 2'b11);
                nw++;
            end
            if (s_rd) begin
                if (nr == abort_at) begin
                    abort = 1'b1;
                    #1;
                    check_eq("abort_ce", {s_ce, s_we}, 2'b00);
                end
                if (run_in_read && nr == 2) run = 1'b1;
                nr++;
            end
            if (s_dr) nd++;
            if (s_dn) ndn++;
            tot++;
            @(negedge clk);
            run = 1'b0;
            abort = 1'b0;
        end
        if (tot >= 700) check_eq("timeout", 1, 0);
        if (abort_at < 0) begin
            check_eq("n_write", nw, n);
            check_eq("n_read", nr, n);
            check_eq("n_drain", nd, (n == 0) ? 0 : lat);
            check_eq("n_done", ndn, 1);
            check_eq("total", tot, (n == 0) ? 1 : 2 * n + lat + 1);
        end else begin
            check_eq("abort_total", tot, n + abort_at + 2);
        end
        check_eq("hold_pass", s_pass, e.pass);
        check_eq("hold_err", s_err, e.err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; run = 1'b0; abort = 1'b0; sel = 1'b0;
        num = '0; start = '0; mode = '0; seed = '0; bad = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_eq("rst_idle", s_idle, 1);
            check_eq("rst_bus", {s_ce, s_we, s_addr, s_d0}, 0);
            check_eq("rst_res", {s_err, s_fea, s_pass, s_ab}, 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_test(1'b0, 16, 8'h00, 2'd0, 8'h00, -1, 1'b0);
        run_test(1'b0, 16, 8'hF8, 2'd2, 8'hA5, -1, 1'b0);
        bad[3] = 1'b1; bad[9] = 1'b1;
        run_test(1'b0, 16, 8'h00, 2'd0, 8'h00, -1, 1'b0);
        bad = '0;
        run_test(1'b1, 8, 8'h10, 2'd1, 8'h00, -1, 1'b0);
        run_test(1'b1, 8, 8'h10, 2'd1, 8'h00, -1, 1'b1);
        bad[8'h13] = 1'b1;
        run_test(1'b1, 8, 8'h10, 2'd2, 8'h5A, -1, 1'b0);
        bad = '0;
        run_test(1'b0, 16, 8'h00, 2'd0, 8'h00, 4, 1'b0);
        check_eq("abort_hold", s_ab, 1);
        run_test(1'b0, 16, 8'h00, 2'd0, 8'h00, -1, 1'b0);
        check_eq("abort_clear", s_ab, 0);
        run_test(1'b0, 0, 8'h20, 2'd0, 8'h00, -1, 1'b0);
        bad = '1;
        run_test(1'b0, 256, 8'h40, 2'd3, 8'h3C, -1, 1'b0);
        bad = '0;

        sel = 1'b0; num = CW'(16); start = 8'h00; mode = 2'd0;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_idle", s_idle, 1);
        check_eq("midrst_bus", {s_ce, s_we, s_addr, s_d0}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
